adc_display_formatter: RTL and testbench

Sits directly downstream of the menu FSM. Consumes its `out_sel` and `hex_BCD_sel` selections. Per sample it:
- picks one of INPUT_TYPES measurement words,
- formats it as either NUM_DIGITS hex nibbles or NUM_DIGITS BCD digits (iterative double-dabble),
- presents the result to the seven-segment driver with a one-cycle valid strobe.

---
 rtl/adc_display_formatter.sv | 200 ++++++++++++++++++++
 tb/tb_adc_display_formatter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adc_display_formatter.sv
// Formats one selected measurement word as hex or BCD digits for the seven-segment driver.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero BCD digits with code 4'hA.
module adc_display_formatter #(
   parameter  int INPUT_TYPES = 5,
   parameter  int DATA_W      = 16,
   parameter  int NUM_DIGITS  = 4,
   localparam int SEL_W       = (INPUT_TYPES > 1) ? $clog2(INPUT_TYPES) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SEL_W-1:0]              out_sel,
   input  logic                          hex_BCD_sel,
   input  logic [INPUT_TYPES*DATA_W-1:0] data_in,
   input  logic                          data_valid,
   output logic [4*NUM_DIGITS-1:0]       digits_out,
   output logic                          digits_valid,
   output logic                          busy,
   output logic                          overflow,
   output logic [1:0]                    dbg_state_o
);

   localparam int HEX_W = 4 * NUM_DIGITS;
   localparam int BCD_W = 4 * (NUM_DIGITS + 1);
   localparam int XW    = (DATA_W > HEX_W) ? DATA_W : HEX_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              ovf_stk_q, ovf_stk_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] pend_word_q, pend_word_d;
   logic              pend_mode_q, pend_mode_d;
   logic [HEX_W-1:0]  digits_q, digits_d;
   logic              ovf_q, ovf_d;
   logic              dv_q, dv_d;

   logic [DATA_W-1:0] sel_word;
   logic [BCD_W-1:0]  bcd_adj;
   logic [XW-1:0]     hex_ext;
   logic              hex_ovf, bcd_ovf;
   logic [HEX_W-1:0]  bcd_disp;
   logic [HEX_W-1:0]  fmt_dig;
   logic              fmt_ovf;
   logic              ld;
   logic [DATA_W-1:0] ld_word;
   logic              ld_mode;

   // Sources beyond INPUT_TYPES fall through to zero.
   always_comb begin
      sel_word = '0;
      for (int k = 0; k < INPUT_TYPES; k++) begin
         if (int'(out_sel) == k) sel_word = data_in[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i <= NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   assign hex_ext = XW'(bin_q);
   assign hex_ovf = |(hex_ext >> HEX_W);
   // A carry out of the extra top digit is remembered so very wide words still flag overflow.
   assign bcd_ovf = ovf_stk_q | (|bcd_q[BCD_W-1 -: 4]);

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic seen;
      seen     = 1'b0;
      bcd_disp = bcd_q[HEX_W-1:0];
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (!seen && (bcd_q[4*i +: 4] == 4'd0)) bcd_disp[4*i +: 4] = 4'hA;
         else                                     seen = 1'b1;
      end
   end
`else
   assign bcd_disp = bcd_q[HEX_W-1:0];
`endif

   always_comb begin
      if (mode_q) begin
         fmt_ovf = bcd_ovf;
         fmt_dig = bcd_ovf ? {NUM_DIGITS{4'h9}} : bcd_disp;
      end else begin
         fmt_ovf = hex_ovf;
         fmt_dig = hex_ovf ? {NUM_DIGITS{4'hF}} : hex_ext[HEX_W-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      ovf_stk_d   = ovf_stk_q;
      pend_d      = pend_q;
      pend_word_d = pend_word_q;
      pend_mode_d = pend_mode_q;
      digits_d    = digits_q;
      ovf_d       = ovf_q;
      dv_d        = 1'b0;
      ld          = 1'b0;
      ld_word     = sel_word;
      ld_mode     = hex_BCD_sel;

      case (state_q)
         IDLE: begin
            ld = data_valid;
         end
         CONVERT: begin
            bcd_d     = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
            bin_d     = {bin_q[DATA_W-2:0], 1'b0};
            ovf_stk_d = ovf_stk_q | bcd_adj[BCD_W-1];
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
            if (data_valid) begin
               pend_d      = 1'b1;
               pend_word_d = sel_word;
               pend_mode_d = hex_BCD_sel;
            end
         end
         DONE: begin
            digits_d = fmt_dig;
            ovf_d    = fmt_ovf;
            dv_d     = 1'b1;
            state_d  = IDLE;
            pend_d   = 1'b0;
            // A strobe arriving in this very cycle is newer than any pending sample.
            if (data_valid) begin
               ld = 1'b1;
            end else if (pend_q) begin
               ld      = 1'b1;
               ld_word = pend_word_q;
               ld_mode = pend_mode_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ld) begin
         bin_d     = ld_word;
         mode_d    = ld_mode;
         bcd_d     = '0;
         ovf_stk_d = 1'b0;
         if (ld_mode) begin
            state_d = CONVERT;
            cnt_d   = CNT_W'(DATA_W);
         end else begin
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         ovf_stk_q   <= 1'b0;
         pend_q      <= 1'b0;
         pend_word_q <= '0;
         pend_mode_q <= 1'b0;
         digits_q    <= '0;
         ovf_q       <= 1'b0;
         dv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         ovf_stk_q   <= ovf_stk_d;
         pend_q      <= pend_d;
         pend_word_q <= pend_word_d;
         pend_mode_q <= pend_mode_d;
         digits_q    <= digits_d;
         ovf_q       <= ovf_d;
         dv_q        <= dv_d;
      end
   end

   assign digits_out   = digits_q;
   assign digits_valid = dv_q;
   assign overflow     = ovf_q;
   assign busy         = (state_q != IDLE);
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_display_formatter.sv
// Scoreboard bench for adc_display_formatter: directed samples push {overflow, digits} and the
// expected output cycle; a negedge monitor pops and compares on every digits_valid.
module tb_adc_display_formatter;

   localparam int IT = 5;
   localparam int DW = 16;
   localparam int ND = 4;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [2:0]     out_sel = '0;
   logic           hex_BCD_sel = 1'b0;
   logic [IT*DW-1:0] data_in;
   logic           data_valid = 1'b0;
   logic [4*ND-1:0] digits_out;
   logic           digits_valid;
   logic           busy;
   logic           overflow;
   logic [1:0]     dbg_state;

   adc_display_formatter #(.INPUT_TYPES(IT), .DATA_W(DW), .NUM_DIGITS(ND)) dut (
      .clk          (clk),
      .reset        (reset),
      .out_sel      (out_sel),
      .hex_BCD_sel  (hex_BCD_sel),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .digits_out   (digits_out),
      .digits_valid (digits_valid),
      .busy         (busy),
      .overflow     (overflow),
      .dbg_state_o  (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard
   logic [16:0] exp_q[$];
   int          cyc_q[$];
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (digits_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_valid: got digits %0h at cycle %0d, expected no output", digits_out, cyc);
         end else begin
            logic [16:0] e;
            int          c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("digits", 32'(digits_out), 32'(e[15:0]));
            check("overflow", 32'(overflow), 32'(e[16]));
            check("valid_cycle", cyc, c);
         end
      end
   end

   // driver: call at a negedge; done_ofs = expected monitor cycle minus the sampling edge
   task automatic send(input logic [2:0] sel, input logic mode, input logic [15:0] word,
                       input bit push, input logic [16:0] exp_v, input int done_ofs);
      out_sel     = sel;
      hex_BCD_sel = mode;
      if (int'(sel) < IT) data_in[int'(sel)*DW +: DW] = word;
      data_valid  = 1'b1;
      if (push) begin
         exp_q.push_back(exp_v);
         cyc_q.push_back(cyc + 1 + done_ofs);
      end
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      data_in = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

      // reset and idle state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_digits", 32'(digits_out), 0);
      check("rst_valid", 32'(digits_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overflow", 32'(overflow), 0);

      // hex, source 2
      send(3'd2, 1'b0, 16'hBEEF, 1'b1, {1'b0, 16'hBEEF}, 1);
      wait_drain(50);

      // BCD 1234 with busy window
      send(3'd0, 1'b1, 16'd1234, 1'b1, {1'b0, 16'h1234}, 17);
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) nb++;
         @(negedge clk);
      end
      check("busy_cycles", nb, 17);
      wait_drain(50);
      repeat (5) @(negedge clk);
      check("hold_digits", 32'(digits_out), 32'h1234);

      send(3'd0, 1'b1, 16'd42, 1'b1, {1'b0, BLANK ? 16'hAA42 : 16'h0042}, 17);
      wait_drain(50);

      // last-wins pending with mode toggles mid-conversion
      send(3'd1, 1'b1, 16'd100, 1'b1, {1'b0, BLANK ? 16'hA100 : 16'h0100}, 17);
      repeat (2) @(negedge clk);
      send(3'd1, 1'b1, 16'd7, 1'b0, 17'd0, 0);
      hex_BCD_sel = 1'b0;
      repeat (2) @(negedge clk);
      send(3'd1, 1'b1, 16'd8, 1'b1, {1'b0, BLANK ? 16'hAAA8 : 16'h0008}, 28);
      hex_BCD_sel = 1'b0;
      wait_drain(80);

      // out-of-range selects latch zero
      send(3'd5, 1'b0, 16'h0000, 1'b1, {1'b0, 16'h0000}, 1);
      wait_drain(20);
      send(3'd7, 1'b1, 16'h0000, 1'b1, {1'b0, BLANK ? 16'hAAA0 : 16'h0000}, 17);
      wait_drain(50);

      // back-to-back hex: second strobe lands in DONE
      send(3'd3, 1'b0, 16'hAAAA, 1'b1, {1'b0, 16'hAAAA}, 1);
      send(3'd4, 1'b0, 16'h5555, 1'b1, {1'b0, 16'h5555}, 1);
      wait_drain(20);

      // BCD with a pending hex sample behind it
      send(3'd0, 1'b1, 16'd5, 1'b1, {1'b0, BLANK ? 16'hAAA5 : 16'h0005}, 17);
      repeat (3) @(negedge clk);
      send(3'd1, 1'b0, 16'h00FF, 1'b1, {1'b0, 16'h00FF}, 14);
      wait_drain(50);

      // BCD range boundaries
      send(3'd0, 1'b1, 16'd9999, 1'b1, {1'b0, 16'h9999}, 17);
      wait_drain(50);
      send(3'd0, 1'b1, 16'd10000, 1'b1, {1'b1, 16'h9999}, 17);
      wait_drain(50);
      send(3'd0, 1'b1, 16'd65535, 1'b1, {1'b1, 16'h9999}, 17);
      wait_drain(50);
      repeat (3) @(negedge clk);
      check("hold_overflow", 32'(overflow), 1);

      // reset during a conversion with a pending sample
      send(3'd2, 1'b1, 16'd500, 1'b0, 17'd0, 0);
      repeat (9) @(negedge clk);
      send(3'd3, 1'b1, 16'd77, 1'b0, 17'd0, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_digits", 32'(digits_out), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_overflow", 32'(overflow), 0);
      check("abort_valid", 32'(digits_valid), 0);
      repeat (40) @(negedge clk);
      check("abort_idle_busy", 32'(busy), 0);
      send(3'd1, 1'b0, 16'h1A2B, 1'b1, {1'b0, 16'h1A2B}, 1);
      wait_drain(20);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
